ex_stage: RTL and testbench
===========================

# ex_stage

Execute stage of the 5-stage MIPS pipeline, directly downstream of instruction decode. It registers the decode bus and computes ALU results and load/store addresses. It drives the data SRAM request and forwards results to decode and to the memory stage. It also contains a 32-iteration radix-2 divider for DIV/DIVU, which holds the front of the pipeline through `stallreq_for_ex` while it runs.

## Interface
Parameters:
- `ID_TO_EX_WD`, default 167: width of the decode bus.
- `EX_TO_MEM_WD`, default 84: width of the memory-stage bus.
- `EX_TO_RF_WD`, default 38: width of the forwarding bus.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `stall` in 6: per-stage stall vector. Stop=1. Bit 2 is EX, bit 3 is MEM.
- `id_to_ex_bus` in 167: fields MSB→LSB:
  - `mem_op[8]`, one-hot in order lb, lbu, lh, lhu, lw, sb, sh, sw
  - `pc[32]`, `inst[32]`
  - `alu_op[12]`, in order add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui
  - `sel_src1[3]`: rs / pc / sa
  - `sel_src2[4]`: rt / sext imm / 8 / zext imm
  - `ram_en`, `ram_wen[4]`, `rf_we`, `rf_waddr[5]`, `sel_rf_res`
  - `rdata1[32]`, `rdata2[32]`
- `ex_to_mem_bus` out 84: `{mem_op, pc, ram_en, ram_wen, sel_rf_res, rf_we, rf_waddr, ex_result}`.
- `ex_to_rf_bus` out 38: `{rf_we, rf_waddr, ex_result}`.
- `memop_to_id` out 8: `mem_op` of the instruction currently in EX.
- `data_sram_en` out 1: data SRAM request.
- `data_sram_wen` out 4: byte write enables.
- `data_sram_addr` out 32: data SRAM address.
- `data_sram_wdata` out 32: data SRAM write data.
- `hi_lo_we` out 1: one-cycle write strobe for HI/LO.
- `hi_o` out 32: remainder.
- `lo_o` out 32: quotient.
- `stallreq_for_ex` out 1: request to stall stages 0–2.

## Operation
- **EX register update:**
  - `rst` → clear to 0.
  - `stall[2]`=1 and `stall[3]`=0 → load 0 (bubble).
  - `stall[2]`=0 → load `id_to_ex_bus`.
  - Otherwise hold.
- **Operand selection (one-hot):**
  - src1 = rs, pc, or `{27'b0, inst[10:6]}`.
  - src2 = rt, `sext(inst[15:0])`, `32'd8`, or `zext(inst[15:0])`.
- **ALU:**
  - add/sub: wrap modulo 2^32, no overflow trap.
  - slt: signed compare; sltu: unsigned compare. Result is 0 or 1.
  - Shifts: src2 shifted by `src1[4:0]`.
  - lui: `{src2[15:0], 16'b0}`.
  - No `alu_op` bit set → result 0.
- **Memory request:**
  - Address = `rdata1 + sext(imm)`. `data_sram_en` = `ram_en` or any load/store in `mem_op`.
  - sw: wen=4'b1111, wdata=rt.
  - sh: wen=4'b0011 or 4'b1100 by `addr[1]`, wdata={2{rt[15:0]}}.
  - sb: wen=4'b0001<<`addr[1:0]`, wdata={4{rt[7:0]}}.
  - Loads: wen=0.
  - Alignment is not checked.
- **Divider detection:** DIV is opcode 0 with func 0x1A; DIVU is opcode 0 with func 0x1B.
- **Divider FSM, states IDLE, BUSY, ZERO, DONE:**
  - IDLE → BUSY: DIV/DIVU in EX, divisor≠0, and `div_done`=0. Latch |rs| and |rt| (raw values for DIVU) and the sign flags. Counter=0.
  - IDLE → ZERO: the same condition with divisor=0.
  - BUSY: one restoring-division step per cycle. Counter increments. BUSY → DONE after counter reaches 31, i.e. 32 steps.
  - ZERO → DONE after 1 cycle. Result is q=32'hFFFF_FFFF, r=rs.
  - DONE: `hi_lo_we`=1 for one cycle. Sign fix-up: quotient is negated when the operand signs differ (DIV only); remainder takes the sign of the dividend. Sets `div_done`. Next state is IDLE.
- **`div_done`:** cleared whenever the EX register loads. This prevents re-issue while the same DIV waits behind a MEM stall.
- **`stallreq_for_ex`:** = (DIV/DIVU in EX and `div_done`=0 and state≠DONE) or state∈{BUSY, ZERO}.
- **Forwarding and bubbles:** `ex_result` for DIV is 0 and `rf_we` passes through unchanged, since the decode stage sets it to 0 for DIV. A bubble (all-zero register) produces `rf_we`=0 and `data_sram_en`=0.

## Timing
- **Reset values:** every output is 0 and the FSM is IDLE. Reset at any point, including in BUSY, aborts the division with no `hi_lo_we`.
- **ALU and memory outputs:** combinational from the EX register, so the result is available in the same cycle the instruction occupies EX. `ex_to_rf_bus` is valid in that same cycle.
- **Division latency:**
  - Cycle E: instruction in EX, IDLE, stall=1.
  - E+1..E+32: BUSY, stall=1.
  - E+33: DONE, stall=0, `hi_lo_we`=1.
  - Total: 33 stall cycles.
- **Divide by zero:** ZERO at E+1, DONE at E+2, so 2 stall cycles.
- **Back-to-back DIVs:** the second DIV loads at the edge after DONE and starts from IDLE on the following cycle.
- **`stall` during BUSY:** has no effect on the FSM.

## Test plan
- **ALU:** addiu rs=0x7FFFFFFF imm=1 → `ex_to_rf_bus` = {1, rt, 0x80000000} in the same cycle. slt 0xFFFFFFFF vs 1 → 1; sltu on the same operands → 0.
- **Stores:** sb rs=0x1000 imm=3 rt=0x12345678 → addr 0x1003, wen 4'b1000, wdata 0x78787878. sh at addr offset 2 → wen 4'b1100.
- **Signed division:** DIV -7/2 → stall high for exactly 33 cycles, then `hi_lo_we` pulse with lo=0xFFFFFFFD and hi=0xFFFFFFFF. DIVU 0xFFFFFFFF/0x10 → lo=0x0FFFFFFF, hi=0xF.
- **Divide by zero:** DIVU 5/0 → stall for 2 cycles, lo=0xFFFFFFFF, hi=5.
- **DIV behind MEM stall:** DIV completes while `stall[3]`=1 holds EX → exactly one `hi_lo_we` pulse, no restart; the FSM stays IDLE until the register reloads.
- **Reset mid-division:** `rst` asserted at BUSY cycle 10 → next cycle all outputs 0, FSM IDLE, no `hi_lo_we`. A bubble load (`stall[2]`=1, `stall[3]`=0) → `memop_to_id`=0, `data_sram_en`=0.

Source files
------------

// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : ex_stage
// Purpose  : MIPS execute stage: EX pipeline register, ALU, data SRAM request
//            generation, forwarding buses and a 32-step restoring divider.
// Revision : 1.0 - initial release
// ============================================================================
module ex_stage #(
    parameter int ID_TO_EX_WD  = 167,
    parameter int EX_TO_MEM_WD = 84,
    parameter int EX_TO_RF_WD  = 38
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [5:0]              stall,
    input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
    output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    output logic [EX_TO_RF_WD-1:0]  ex_to_rf_bus,
    output logic [7:0]              memop_to_id,
    output logic                    data_sram_en,
    output logic [3:0]              data_sram_wen,
    output logic [31:0]             data_sram_addr,
    output logic [31:0]             data_sram_wdata,
    output logic                    hi_lo_we,
    output logic [31:0]             hi_o,
    output logic [31:0]             lo_o,
    output logic                    stallreq_for_ex
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_busy = 2'd1;
    localparam logic [1:0] c_st_zero = 2'd2;
    localparam logic [1:0] c_st_done = 2'd3;

    logic [ID_TO_EX_WD-1:0] r_ex_bus;
    logic                   w_ex_load;

    assign w_ex_load = !(stall[2] && stall[3]);

    // A stalled EX with a running MEM stage takes a bubble; both stalled holds.
    always_ff @(posedge clk) begin
        if (rst)
            r_ex_bus <= '0;
        else if (!stall[2])
            r_ex_bus <= id_to_ex_bus;
        else if (!stall[3])
            r_ex_bus <= '0;
    end

    logic [7:0]  w_mem_op;
    logic [31:0] w_pc, w_inst, w_rdata1, w_rdata2;
    logic [11:0] w_alu_op;
    logic [2:0]  w_sel_src1;
    logic [3:0]  w_sel_src2, w_ram_wen;
    logic        w_ram_en, w_rf_we, w_sel_rf_res;
    logic [4:0]  w_rf_waddr;

    assign {w_mem_op, w_pc, w_inst, w_alu_op, w_sel_src1, w_sel_src2, w_ram_en,
            w_ram_wen, w_rf_we, w_rf_waddr, w_sel_rf_res, w_rdata1, w_rdata2} = r_ex_bus;

    logic [31:0] w_imm_sext, w_imm_zext, w_src1, w_src2, w_alu_res, w_ex_result;

    assign w_imm_sext = {{16{w_inst[15]}}, w_inst[15:0]};
    assign w_imm_zext = {16'd0, w_inst[15:0]};
    assign w_src1 = ({32{w_sel_src1[2]}} & w_rdata1)
                  | ({32{w_sel_src1[1]}} & w_pc)
                  | ({32{w_sel_src1[0]}} & {27'd0, w_inst[10:6]});
    assign w_src2 = ({32{w_sel_src2[3]}} & w_rdata2)
                  | ({32{w_sel_src2[2]}} & w_imm_sext)
                  | ({32{w_sel_src2[1]}} & 32'd8)
                  | ({32{w_sel_src2[0]}} & w_imm_zext);

    always_comb begin
        w_alu_res = 32'd0;
        if      (w_alu_op[11]) w_alu_res = w_src1 + w_src2;
        else if (w_alu_op[10]) w_alu_res = w_src1 - w_src2;
        else if (w_alu_op[9])  w_alu_res = {31'd0, $signed(w_src1) < $signed(w_src2)};
        else if (w_alu_op[8])  w_alu_res = {31'd0, w_src1 < w_src2};
        else if (w_alu_op[7])  w_alu_res = w_src1 & w_src2;
        else if (w_alu_op[6])  w_alu_res = ~(w_src1 | w_src2);
        else if (w_alu_op[5])  w_alu_res = w_src1 | w_src2;
        else if (w_alu_op[4])  w_alu_res = w_src1 ^ w_src2;
        else if (w_alu_op[3])  w_alu_res = w_src2 << w_src1[4:0];
        else if (w_alu_op[2])  w_alu_res = w_src2 >> w_src1[4:0];
        else if (w_alu_op[1])  w_alu_res = $unsigned($signed(w_src2) >>> w_src1[4:0]);
        else if (w_alu_op[0])  w_alu_res = {w_src2[15:0], 16'd0};
    end

    logic w_is_div, w_div_signed;
    assign w_is_div     = (w_inst[31:26] == 6'd0) && (w_inst[5:1] == 5'b01101);
    assign w_div_signed = !w_inst[0];

    // DIV writes HI/LO only; the register-file result is forced to zero.
    assign w_ex_result = w_is_div ? 32'd0 : w_alu_res;

    logic [31:0] w_addr;
    assign w_addr = w_rdata1 + w_imm_sext;

    always_comb begin
        data_sram_wen   = 4'd0;
        data_sram_wdata = w_rdata2;
        if (w_mem_op[0]) begin
            data_sram_wen = 4'b1111;
        end else if (w_mem_op[1]) begin
            data_sram_wen   = w_addr[1] ? 4'b1100 : 4'b0011;
            data_sram_wdata = {2{w_rdata2[15:0]}};
        end else if (w_mem_op[2]) begin
            data_sram_wen   = 4'b0001 << w_addr[1:0];
            data_sram_wdata = {4{w_rdata2[7:0]}};
        end else if (w_mem_op[7:3] == 5'd0) begin
            data_sram_wen = w_ram_wen;
        end
    end

    assign data_sram_en   = w_ram_en || (w_mem_op != 8'd0);
    assign data_sram_addr = w_addr;
    assign memop_to_id    = w_mem_op;
    assign ex_to_rf_bus   = {w_rf_we, w_rf_waddr, w_ex_result};
    assign ex_to_mem_bus  = {w_mem_op, w_pc, w_ram_en, w_ram_wen, w_sel_rf_res,
                             w_rf_we, w_rf_waddr, w_ex_result};

    logic [1:0]  r_state;
    logic [4:0]  r_cnt;
    logic [31:0] r_quot, r_rem, r_divisor;
    logic        r_neg_q, r_neg_r, r_div_done;
    logic [31:0] w_abs_rs, w_abs_rt;
    logic [32:0] w_partial, w_diff;
    logic        w_start;

    assign w_abs_rs  = (w_div_signed && w_rdata1[31]) ? -w_rdata1 : w_rdata1;
    assign w_abs_rt  = (w_div_signed && w_rdata2[31]) ? -w_rdata2 : w_rdata2;
    assign w_start   = (r_state == c_st_idle) && w_is_div && !r_div_done;
    // Dividend bits shift out of the quotient register into the remainder.
    assign w_partial = {r_rem, r_quot[31]};
    assign w_diff    = w_partial - {1'b0, r_divisor};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_st_idle;
            r_cnt     <= 5'd0;
            r_quot    <= 32'd0;
            r_rem     <= 32'd0;
            r_divisor <= 32'd0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_start && (w_rdata2 == 32'd0)) begin
                        r_state <= c_st_zero;
                        r_quot  <= 32'hFFFF_FFFF;
                        r_rem   <= w_rdata1;
                        r_neg_q <= 1'b0;
                        r_neg_r <= 1'b0;
                    end else if (w_start) begin
                        r_state   <= c_st_busy;
                        r_quot    <= w_abs_rs;
                        r_rem     <= 32'd0;
                        r_divisor <= w_abs_rt;
                        r_neg_q   <= w_div_signed && (w_rdata1[31] ^ w_rdata2[31]);
                        r_neg_r   <= w_div_signed && w_rdata1[31];
                        r_cnt     <= 5'd0;
                    end
                end
                c_st_busy: begin
                    if (!w_diff[32]) begin
                        r_rem  <= w_diff[31:0];
                        r_quot <= {r_quot[30:0], 1'b1};
                    end else begin
                        r_rem  <= w_partial[31:0];
                        r_quot <= {r_quot[30:0], 1'b0};
                    end
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31)
                        r_state <= c_st_done;
                end
                c_st_zero: r_state <= c_st_done;
                default:   r_state <= c_st_idle;
            endcase
        end
    end

    // A reload wins over DONE so a back-to-back DIV can start immediately.
    always_ff @(posedge clk) begin
        if (rst)
            r_div_done <= 1'b0;
        else if (w_ex_load)
            r_div_done <= 1'b0;
        else if (r_state == c_st_done)
            r_div_done <= 1'b1;
    end

    assign hi_lo_we        = (r_state == c_st_done);
    assign lo_o            = r_neg_q ? -r_quot : r_quot;
    assign hi_o            = r_neg_r ? -r_rem : r_rem;
    assign stallreq_for_ex = (w_is_div && !r_div_done && (r_state != c_st_done))
                           || (r_state == c_st_busy) || (r_state == c_st_zero);

    logic w_unused;
    assign w_unused = ^{stall[5:4], stall[1:0], w_inst[25:16]};

endmodule
`default_nettype wire

// File: tb/tb_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_stage
// Purpose  : Self-checking bench for ex_stage with a HI/LO result scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_stage;

    typedef struct packed {
        logic [7:0]  mem_op;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [11:0] alu_op;
        logic [2:0]  sel_src1;
        logic [3:0]  sel_src2;
        logic        ram_en;
        logic [3:0]  ram_wen;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic        sel_rf_res;
        logic [31:0] rdata1;
        logic [31:0] rdata2;
    } id_bus_t;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } hilo_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [5:0]   stall;
    logic [166:0] id_to_ex_bus;
    logic [83:0]  ex_to_mem_bus;
    logic [37:0]  ex_to_rf_bus;
    logic [7:0]   memop_to_id;
    logic         data_sram_en;
    logic [3:0]   data_sram_wen;
    logic [31:0]  data_sram_addr, data_sram_wdata, hi_o, lo_o;
    logic         hi_lo_we, stallreq_for_ex;

    int    n_tests = 0;
    int    n_fail  = 0;
    int    n_hilo  = 0;
    hilo_t exp_q[$];

    ex_stage dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .id_to_ex_bus    (id_to_ex_bus),
        .ex_to_mem_bus   (ex_to_mem_bus),
        .ex_to_rf_bus    (ex_to_rf_bus),
        .memop_to_id     (memop_to_id),
        .data_sram_en    (data_sram_en),
        .data_sram_wen   (data_sram_wen),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .hi_lo_we        (hi_lo_we),
        .hi_o            (hi_o),
        .lo_o            (lo_o),
        .stallreq_for_ex (stallreq_for_ex)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [83:0] got, input logic [83:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic id_bus_t mk(input logic [7:0] mop, input logic [11:0] aop,
                                   input logic [2:0] s1, input logic [3:0] s2,
                                   input logic [31:0] inst, input logic [31:0] rd1,
                                   input logic [31:0] rd2, input logic we,
                                   input logic [4:0] wa);
        id_bus_t b;
        b.mem_op     = mop;
        b.pc         = 32'hBFC0_0100;
        b.inst       = inst;
        b.alu_op     = aop;
        b.sel_src1   = s1;
        b.sel_src2   = s2;
        b.ram_en     = (mop != 8'd0);
        b.ram_wen    = 4'd0;
        b.rf_we      = we;
        b.rf_waddr   = wa;
        b.sel_rf_res = (mop[7:3] != 5'd0);
        b.rdata1     = rd1;
        b.rdata2     = rd2;
        return b;
    endfunction

    // Scoreboard consumer: every HI/LO strobe must match the oldest expected result.
    always @(negedge clk) begin
        if (!rst && hi_lo_we) begin
            n_hilo++;
            if (exp_q.size() == 0) begin
                check("hilo_unexpected", 1, 0);
            end else begin
                hilo_t e;
                e = exp_q.pop_front();
                check("div_lo", lo_o, e.lo);
                check("div_hi", hi_o, e.hi);
            end
        end
    end

    task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] eq, input logic [31:0] er, input int exp_stall);
        hilo_t e;
        int    cnt;
        // ALU op left as add so a non-zero sum would expose a missing result mask.
        id_to_ex_bus = mk(8'd0, 12'h800, 3'b100, 4'b1000,
                          {6'd0, 5'd4, 5'd5, 10'd0, sgn ? 6'h1a : 6'h1b}, a, b, 1'b0, 5'd0);
        stall = 6'd0;
        e.hi = er;
        e.lo = eq;
        exp_q.push_back(e);
        tick();
        check("div_fwd_zero", ex_to_rf_bus, 38'd0);
        cnt = 0;
        while (stallreq_for_ex && cnt < 100) begin
            stall = 6'b001111;
            cnt++;
            tick();
        end
        check("div_stall_cycles", cnt, exp_stall);
        check("div_we_at_release", hi_lo_we, 1);
    endtask

    id_bus_t b;
    int      n0;
    int      sr_hits;

    initial begin
        rst = 1'b1;
        stall = 6'd0;
        id_to_ex_bus = '0;
        tick();
        tick();
        check("rst_rf_bus", ex_to_rf_bus, 38'd0);
        check("rst_mem_bus", ex_to_mem_bus, 84'd0);
        check("rst_stallreq", stallreq_for_ex, 0);
        check("rst_hilo", {hi_lo_we, hi_o, lo_o}, 65'd0);
        check("rst_sram_en", data_sram_en, 0);
        rst = 1'b0;

        // addiu overflow wraps
        id_to_ex_bus = mk(8'd0, 12'h800, 3'b100, 4'b0100, {6'h09, 5'd1, 5'd5, 16'h0001},
                          32'h7FFF_FFFF, 32'd0, 1'b1, 5'd5);
        tick();
        check("addiu", ex_to_rf_bus, {1'b1, 5'd5, 32'h8000_0000});

        id_to_ex_bus = mk(8'd0, 12'h200, 3'b100, 4'b1000, 32'h0022_182A,
                          32'hFFFF_FFFF, 32'd1, 1'b1, 5'd3);
        tick();
        check("slt", ex_to_rf_bus[31:0], 32'd1);

        id_to_ex_bus = mk(8'd0, 12'h100, 3'b100, 4'b1000, 32'h0022_182B,
                          32'hFFFF_FFFF, 32'd1, 1'b1, 5'd3);
        tick();
        check("sltu", ex_to_rf_bus[31:0], 32'd0);

        id_to_ex_bus = mk(8'd0, 12'h400, 3'b100, 4'b1000, 32'h0022_1823,
                          32'd0, 32'd1, 1'b1, 5'd3);
        tick();
        check("sub_wrap", ex_to_rf_bus[31:0], 32'hFFFF_FFFF);

        id_to_ex_bus = mk(8'd0, 12'h002, 3'b001, 4'b1000, {21'd0, 5'd4, 6'h03},
                          32'd0, 32'h8000_0000, 1'b1, 5'd3);
        tick();
        check("sra", ex_to_rf_bus[31:0], 32'hF800_0000);

        id_to_ex_bus = mk(8'd0, 12'h001, 3'b000, 4'b0001, {6'h0F, 5'd0, 5'd7, 16'h1234},
                          32'd0, 32'd0, 1'b1, 5'd7);
        tick();
        check("lui", ex_to_rf_bus, {1'b1, 5'd7, 32'h1234_0000});

        id_to_ex_bus = mk(8'd0, 12'h000, 3'b100, 4'b1000, 32'h0000_0000,
                          32'h5555_5555, 32'h1111_1111, 1'b0, 5'd0);
        tick();
        check("no_aluop", ex_to_rf_bus[31:0], 32'd0);

        // sb at byte offset 3
        id_to_ex_bus = mk(8'b0000_0100, 12'h800, 3'b100, 4'b0100, {6'h28, 5'd1, 5'd2, 16'h0003},
                          32'h0000_1000, 32'h1234_5678, 1'b0, 5'd0);
        tick();
        check("sb_addr", data_sram_addr, 32'h0000_1003);
        check("sb_wen", data_sram_wen, 4'b1000);
        check("sb_wdata", data_sram_wdata, 32'h7878_7878);
        check("sb_en", data_sram_en, 1);

        id_to_ex_bus = mk(8'b0000_0010, 12'h800, 3'b100, 4'b0100, {6'h29, 5'd1, 5'd2, 16'h0002},
                          32'h0000_1000, 32'h1234_5678, 1'b0, 5'd0);
        tick();
        check("sh_wen", data_sram_wen, 4'b1100);
        check("sh_wdata", data_sram_wdata, 32'h5678_5678);

        b = mk(8'b0000_0001, 12'h800, 3'b100, 4'b0100, {6'h2B, 5'd1, 5'd2, 16'hFFFC},
               32'h0000_2000, 32'hCAFE_BABE, 1'b0, 5'd0);
        id_to_ex_bus = b;
        tick();
        check("sw_wen", data_sram_wen, 4'b1111);
        check("sw_mem_bus", ex_to_mem_bus,
              {8'b0000_0001, 32'hBFC0_0100, 1'b1, 4'd0, 1'b0, 1'b0, 5'd0, 32'h0000_1FFC});
        check("sw_memop_to_id", memop_to_id, 8'b0000_0001);

        id_to_ex_bus = mk(8'b0000_1000, 12'h800, 3'b100, 4'b0100, {6'h23, 5'd1, 5'd2, 16'h0004},
                          32'h0000_3000, 32'hFFFF_FFFF, 1'b1, 5'd2);
        tick();
        check("lw_wen", data_sram_wen, 4'd0);
        check("lw_en", data_sram_en, 1);
        check("lw_rf_bus", ex_to_rf_bus, {1'b1, 5'd2, 32'h0000_3004});

        // hold with both EX and MEM stalled, then a bubble
        id_to_ex_bus = b;
        stall = 6'b001100;
        tick();
        check("hold_memop", memop_to_id, 8'b0000_1000);
        stall = 6'b000100;
        tick();
        check("bubble_memop", memop_to_id, 8'd0);
        check("bubble_en", data_sram_en, 0);
        check("bubble_rf_we", ex_to_rf_bus[37], 0);
        stall = 6'd0;

        run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33);
        run_div(1'b1, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2, 33);
        run_div(1'b0, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 32'hF, 33);
        run_div(1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 2);
        id_to_ex_bus = '0;
        stall = 6'd0;
        tick();

        // DIV completes while MEM stall keeps it parked in EX
        n0 = n_hilo;
        run_div(1'b1, 32'h8000_0000, 32'd3, 32'hD555_5556, 32'hFFFF_FFFE, 33);
        sr_hits = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (stallreq_for_ex) sr_hits++;
        end
        check("memstall_no_restart", sr_hits, 0);
        check("memstall_one_pulse", n_hilo - n0, 1);
        id_to_ex_bus = '0;
        stall = 6'd0;
        tick();

        // reset during BUSY aborts the division
        id_to_ex_bus = mk(8'd0, 12'h000, 3'b100, 4'b1000, {6'd0, 5'd4, 5'd5, 10'd0, 6'h1a},
                          32'd1000, 32'd7, 1'b0, 5'd0);
        stall = 6'd0;
        n0 = n_hilo;
        tick();
        stall = 6'b001111;
        repeat (10) tick();
        check("busy_stallreq", stallreq_for_ex, 1);
        rst = 1'b1;
        tick();
        check("midrst_stallreq", stallreq_for_ex, 0);
        check("midrst_hilo", {hi_lo_we, hi_o, lo_o}, 65'd0);
        check("midrst_rf_bus", ex_to_rf_bus, 38'd0);
        check("midrst_mem_bus", ex_to_mem_bus, 84'd0);
        rst = 1'b0;
        stall = 6'd0;
        id_to_ex_bus = '0;
        repeat (40) tick();
        check("midrst_no_pulse", n_hilo - n0, 0);
        check("sb_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
